// File: rtl/shift_tx.sv
// rtl/shift_tx.sv - parallel-in / serial-out frame transmitter, LSB first
//
// Purpose:
//   Accepts a WIDTH-bit word over a load_valid/load_ready handshake and
//   presents it on ser_out one bit per enabled clock, LSB first. With the
//   SHIFT_TX_PARITY_EN macro defined, an even-parity bit is appended and
//   ser_last moves to that parity bit.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   load_data  in   [WIDTH] parallel word to transmit
//   load_valid in   load_data is valid
//   load_ready out  word can be accepted (idle only)
//   shift_en   in   advance to the next serial bit on this edge
//   ser_out    out  current serial bit
//   ser_valid  out  ser_out carries a frame bit
//   ser_last   out  current bit is the final bit of the frame
//   busy       out  frame in progress (inverse of load_ready)
//
// Configuration macro: SHIFT_TX_PARITY_EN

module shift_tx #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SHIFT_TX_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic {IDLE, SHIFT} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SHIFT_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   logic load_ready_q, load_ready_d;
   logic ser_out_q, ser_out_d;
   logic ser_valid_q, ser_valid_d;
   logic ser_last_q, ser_last_d;

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
`ifdef SHIFT_TX_PARITY_EN
      par_d   = par_q;
`endif

      case (state_q)
         IDLE: begin
            if (load_valid) begin
               sreg_d  = load_data;
               cnt_d   = '0;
`ifdef SHIFT_TX_PARITY_EN
               par_d   = ^load_data;
`endif
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (shift_en) begin
               if (cnt_q == LAST) begin
`ifdef SHIFT_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = IDLE;
`endif
               end else begin
                  sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
                  cnt_d  = cnt_q + CW'(1);
               end
            end
         end
`ifdef SHIFT_TX_PARITY_EN
         PARITY: begin
            if (shift_en) state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase

      // Outputs are computed from the next state so they can be registered
      // alongside it and appear in the same cycle as the state they describe.
      load_ready_d = 1'b0;
      ser_out_d    = 1'b0;
      ser_valid_d  = 1'b0;
      ser_last_d   = 1'b0;
      case (state_d)
         IDLE: load_ready_d = 1'b1;
         SHIFT: begin
            ser_out_d   = sreg_d[0];
            ser_valid_d = 1'b1;
`ifdef SHIFT_TX_PARITY_EN
            ser_last_d  = 1'b0;
`else
            ser_last_d  = (cnt_d == LAST);
`endif
         end
`ifdef SHIFT_TX_PARITY_EN
         PARITY: begin
            ser_out_d   = par_d;
            ser_valid_d = 1'b1;
            ser_last_d  = 1'b1;
         end
`endif
         default: load_ready_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sreg_q       <= '0;
         cnt_q        <= '0;
`ifdef SHIFT_TX_PARITY_EN
         par_q        <= 1'b0;
`endif
         load_ready_q <= 1'b1;
         ser_out_q    <= 1'b0;
         ser_valid_q  <= 1'b0;
         ser_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sreg_q       <= sreg_d;
         cnt_q        <= cnt_d;
`ifdef SHIFT_TX_PARITY_EN
         par_q        <= par_d;
`endif
         load_ready_q <= load_ready_d;
         ser_out_q    <= ser_out_d;
         ser_valid_q  <= ser_valid_d;
         ser_last_q   <= ser_last_d;
      end
   end

   assign load_ready = load_ready_q;
   assign busy       = ~load_ready_q;
   assign ser_out    = ser_out_q;
   assign ser_valid  = ser_valid_q;
   assign ser_last   = ser_last_q;

endmodule

// File: tb/tb_shift_tx.sv
// tb/tb_shift_tx.sv - self-checking bench for shift_tx

module tb_shift_tx;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] load_data;
   logic             load_valid;
   logic             load_ready;
   logic             shift_en;
   logic             ser_out;
   logic             ser_valid;
   logic             ser_last;
   logic             busy;

   int checks = 0;
   int errors = 0;

   shift_tx #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_data  (load_data),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .shift_en   (shift_en),
      .ser_out    (ser_out),
      .ser_valid  (ser_valid),
      .ser_last   (ser_last),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not reach the summary");
      $fatal(1);
   end

   task automatic check_idle(input string name);
      checks++;
      if ({load_ready, busy, ser_valid, ser_out, ser_last} !== 5'b10000) begin
         errors++;
         $display("FAIL %s: ready/busy/valid/out/last=%b required 10000", name,
                  {load_ready, busy, ser_valid, ser_out, ser_last});
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with it idle.
   // mode 0: shift_en always high; 1: random stalls; 2: stall 3 cycles after bit 0.
   task automatic send_frame(input logic [WIDTH-1:0] word, input int mode, input bit inject);
      logic exp_q[$];
      int   k;
      int   cyc;
      exp_q = {};
      for (int i = 0; i < WIDTH; i++) exp_q.push_back(word[i]);
`ifdef SHIFT_TX_PARITY_EN
      exp_q.push_back(($countones(word) % 2) == 1);
`endif
      checks++;
      if (load_ready !== 1'b1) begin
         errors++;
         $display("FAIL pre_load_ready: got %b required 1", load_ready);
      end
      load_data  = word;
      load_valid = 1'b1;
      shift_en   = 1'($urandom_range(1));
      k   = 0;
      cyc = 0;
      while (k < exp_q.size() && cyc < 200) begin
         @(negedge clk);
         checks++;
         if ({ser_valid, busy, load_ready} !== 3'b110) begin
            errors++;
            $display("FAIL frame_flags word=%b bit=%0d: valid/busy/ready=%b required 110",
                     word, k, {ser_valid, busy, load_ready});
         end
         checks++;
         if (ser_out !== exp_q[k]) begin
            errors++;
            $display("FAIL ser_out word=%b bit=%0d: got %b required %b", word, k, ser_out, exp_q[k]);
         end
         checks++;
         if (ser_last !== (k == exp_q.size() - 1)) begin
            errors++;
            $display("FAIL ser_last word=%b bit=%0d: got %b required %b", word, k, ser_last,
                     (k == exp_q.size() - 1));
         end
         load_valid = inject;
         load_data  = inject ? ~word : WIDTH'($urandom);
         case (mode)
            0:       shift_en = 1'b1;
            1:       shift_en = ($urandom_range(99) >= 40);
            default: shift_en = !(cyc >= 1 && cyc <= 3);
         endcase
         if (shift_en) k++;
         cyc++;
      end
      checks++;
      if (k != exp_q.size()) begin
         errors++;
         $display("FAIL frame_timeout word=%b: consumed %0d bits required %0d", word, k, exp_q.size());
      end
      @(negedge clk);
      check_idle("post_frame_idle");
      load_valid = 1'b0;
      shift_en   = 1'($urandom_range(1));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle("reset_held");
      rst = 1'b0;
      @(negedge clk);
      check_idle("reset_released");
   endtask

   task automatic test_basic();
      send_frame(4'b1011, 0, 1'b0);
      send_frame(4'b0110, 0, 1'b0);
   endtask

   task automatic test_hold();
      send_frame(4'b1011, 2, 1'b0);
   endtask

   task automatic test_busy_ignore();
      send_frame(4'b1011, 0, 1'b1);
   endtask

   task automatic test_reset_midframe();
      logic [WIDTH-1:0] w;
      w = 4'b1011;
      load_data  = w;
      load_valid = 1'b1;
      shift_en   = 1'b1;
      for (int k = 0; k <= 2; k++) begin
         @(negedge clk);
         load_valid = 1'b0;
         checks++;
         if (ser_valid !== 1'b1 || ser_out !== w[k]) begin
            errors++;
            $display("FAIL midframe_bit%0d: valid/out=%b%b required 1%b", k, ser_valid, ser_out, w[k]);
         end
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("reset_midframe");
      send_frame(4'b0110, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) send_frame(WIDTH'($urandom), 0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++)
         send_frame(WIDTH'($urandom), 1, 1'($urandom_range(1)));
   endtask

   initial begin
      rst        = 1'b1;
      load_data  = '0;
      load_valid = 1'b0;
      shift_en   = 1'b0;
      test_reset();
      test_basic();
      test_hold();
      test_busy_ignore();
      test_reset_midframe();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_tx.md
# shift_tx

Parallel-in / serial-out frame transmitter: accepts a `width`-bit word over a valid/ready handshake and shifts it out one bit per enabled clock, LSB first. It is the sending end for the universal shift register's serial-load mode. That register shifts each new bit in at the MSB, so after `width` shifts the word is in its original bit positions. The block sits upstream of that register: its `ser_out` drives the register's serial input, and its `shift_en` is driven from the receiver-side shift strobe.

## Interface
- `width`, 4, data word width in bits; legal range ≥ 2.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `load_data`  input  `width`  parallel word to transmit.
- `load_valid`  input  1  `load_data` is valid.
- `load_ready`  output  1  block can accept a word (high only in IDLE).
- `shift_en`  input  1  advance to the next serial bit on this edge; low = hold the current bit.
- `ser_out`  output  1  current serial bit.
- `ser_valid`  output  1  `ser_out` carries a frame bit.
- `ser_last`  output  1  current bit is the final bit of the frame.
- `busy`  output  1  frame in progress (inverse of `load_ready`).

## Operation
- Registered FSM with states IDLE, SHIFT and (only with the macro) PARITY.
- Datapath: shift register `sreg[width-1:0]`, bit counter `cnt` of `$clog2(width)` bits, parity flop `par`.
- **IDLE**
  - Outputs: `load_ready`=1, `busy`=0, `ser_valid`=0, `ser_out`=0, `ser_last`=0.
  - On `load_valid`=1: `sreg`←`load_data`, `cnt`←0, `par`←^`load_data`, next state SHIFT.
- **SHIFT**
  - Outputs: `ser_out`=`sreg[0]`, `ser_valid`=1, `busy`=1, `load_ready`=0.
  - `ser_last`=(`cnt`==`width`-1), unless the parity feature is compiled in.
  - On `shift_en`=1 and `cnt`<`width`-1: `sreg`←{1'b0, `sreg[width-1:1]`}, `cnt`←`cnt`+1.
  - On `shift_en`=1 and `cnt`==`width`-1: next state IDLE, or PARITY if the macro is defined.
  - On `shift_en`=0: all state holds; `ser_out` and `ser_valid` stay stable.
- **PARITY**
  - Outputs: `ser_out`=`par`, `ser_valid`=1, `ser_last`=1.
  - On `shift_en`=1: next state IDLE.
- While `busy`=1, `load_valid` and `load_data` are ignored; no word is queued.
- `shift_en` is ignored in IDLE.
- `cnt` never wraps; it resets to 0 on every accepted load.

## Timing
- Reset (`rst`=1 at an edge): state←IDLE, `sreg`←0, `cnt`←0, `par`←0.
  - Outputs after that edge: `load_ready`=1, `busy`=0, `ser_valid`=0, `ser_out`=0, `ser_last`=0.
- Reset has priority over every other input, including mid-frame. The frame is abandoned and no further bits are emitted.
- Load at edge N (`load_valid`&`load_ready`) → bit 0 is on `ser_out` with `ser_valid`=1 from edge N until edge N+1.
- With `shift_en` held high, bit k is presented in the cycle after edge N+k.
  - A frame occupies `width` cycles, or `width`+1 with parity.
- `load_ready` rises in the cycle after the edge that consumes the last bit. Minimum spacing from one load to the next is `width`+1 cycles (`width`+2 with parity).
- A load and the last-bit consume cannot coincide, because `load_ready`=0 during the frame.
- All outputs are decoded from registered state only; there is no combinational path from any input to any output.

## Configuration
- Macro `SHIFT_TX_PARITY_EN`.
- Defined:
  - PARITY state is compiled in; frame length is `width`+1.
  - The appended bit is even parity, i.e. XOR of all data bits, so the total count of ones in the frame is even.
  - `ser_last` is asserted only on the parity bit.
- Undefined:
  - PARITY state and the `par` flop are absent; frame length is `width`.
  - `ser_last` is asserted on data bit `width`-1.

## Test plan
1. `rst`=1 for 2 cycles, then 0 → `load_ready`=1, `busy`=0, `ser_valid`=0, `ser_out`=0, `ser_last`=0.
2. `width`=4, load 4'b1011, `shift_en`=1 continuously → `ser_out` = 1,1,0,1 on 4 consecutive cycles with `ser_valid`=1; `ser_last`=1 on the 4th bit only; `load_ready`=1 on the 5th cycle.
3. Load 4'b1011, drop `shift_en` for 3 cycles after the first bit is consumed → `ser_out` holds 1 (bit 1) and `ser_valid` stays 1 for those 3 cycles; the remaining bits 0,1 follow once `shift_en` returns high.
4. During a frame of 4'b1011, present `load_valid`=1 with 4'b0110 → word not accepted, serial output remains 1,1,0,1, `load_ready` stays 0 until the frame ends.
5. Assert `rst` for one cycle while bit 2 is on `ser_out` → next cycle IDLE: `ser_valid`=0, `load_ready`=1; a subsequent load of 4'b0110 transmits 0,1,1,0 cleanly.
6. With `SHIFT_TX_PARITY_EN` defined, load 4'b1011 → `ser_out` = 1,1,0,1,1; `ser_last`=1 only on the 5th bit; with 4'b0110 the 5th bit is 0.
